// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: waits out power-up, precharges all banks,
// issues N_REFRESH auto refreshes and a LOAD MODE, then hands the bus to the controller.
module sdram_init_seq #(
    parameter int         ASIZE       = 12,
    parameter int         BASIZE      = 2,
    parameter int         T_POWERUP   = 20000,
    parameter int         T_RP        = 2,
    parameter int         T_RFC       = 7,
    parameter int         T_MRD       = 2,
    parameter int         N_REFRESH   = 8,
    parameter logic [2:0] BURST_LEN   = 3'b011,
    parameter logic       BURST_TYPE  = 1'b0,
    parameter logic [2:0] CAS_LAT     = 3'b011,
    parameter logic       WRITE_BURST = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Reinit_req,
    output logic              Cke,
    output logic [3:0]        Command,
    output logic [ASIZE-1:0]  Saddr,
    output logic [BASIZE-1:0] Ba,
    output logic              Init_done,
    output logic              Busy
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    localparam int T_MAX_A = (T_POWERUP > T_RP)  ? T_POWERUP : T_RP;
    localparam int T_MAX_B = (T_RFC > T_MRD)     ? T_RFC     : T_MRD;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A   : T_MAX_B;
    localparam int CW      = $clog2(T_MAX + 1);
    localparam int RW      = $clog2(N_REFRESH + 1);

    localparam logic [ASIZE-1:0] PRE_ADDR  = ASIZE'(1024);
    localparam logic [ASIZE-1:0] MODE_WORD =
        ASIZE'({WRITE_BURST, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN});

    localparam logic [2:0] ST_WAIT = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_TRP  = 3'd2;
    localparam logic [2:0] ST_REF  = 3'd3;
    localparam logic [2:0] ST_TRFC = 3'd4;
    localparam logic [2:0] ST_MRS  = 3'd5;
    localparam logic [2:0] ST_TMRD = 3'd6;
    localparam logic [2:0] ST_DONE = 3'd7;

    logic [2:0]       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [RW-1:0]    ref_cnt, ref_d;
    logic [3:0]       cmd_d;
    logic [ASIZE-1:0] saddr_d;
    logic             done_d;
    logic             go_pre, go_ref, go_mrs, go_done;

    // Outside WAIT, cnt holds the NOP cycles still owed before the next command,
    // so a spacing of 1 chains commands back to back straight from the command state.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ref_d   = ref_cnt;
        cmd_d   = CMD_NOP;
        saddr_d = '0;
        done_d  = 1'b0;
        go_pre  = 1'b0;
        go_ref  = 1'b0;
        go_mrs  = 1'b0;
        go_done = 1'b0;

        case (state)
            ST_WAIT: begin
                if (cnt == CW'(T_POWERUP)) go_pre = 1'b1;
                else                       cnt_d  = cnt + CW'(1);
            end
            ST_PRE, ST_TRP: begin
                if (cnt == '0) go_ref = 1'b1;
                else begin
                    state_d = ST_TRP;
                    cnt_d   = cnt - CW'(1);
                end
            end
            ST_REF, ST_TRFC: begin
                if (cnt == '0) begin
                    if (ref_cnt == RW'(N_REFRESH)) go_mrs = 1'b1;
                    else                           go_ref = 1'b1;
                end else begin
                    state_d = ST_TRFC;
                    cnt_d   = cnt - CW'(1);
                end
            end
            ST_MRS, ST_TMRD: begin
                if (cnt == '0) go_done = 1'b1;
                else begin
                    state_d = ST_TMRD;
                    cnt_d   = cnt - CW'(1);
                end
            end
            ST_DONE: begin
                go_pre  = Reinit_req;
                go_done = ~Reinit_req;
            end
            default: state_d = ST_WAIT;
        endcase

        if (go_pre) begin
            state_d = ST_PRE;
            cnt_d   = CW'(T_RP - 1);
            ref_d   = '0;
            cmd_d   = CMD_PRE;
            saddr_d = PRE_ADDR;
        end
        if (go_ref) begin
            state_d = ST_REF;
            cnt_d   = CW'(T_RFC - 1);
            ref_d   = ref_cnt + RW'(1);
            cmd_d   = CMD_REF;
        end
        if (go_mrs) begin
            state_d = ST_MRS;
            cnt_d   = CW'(T_MRD - 1);
            cmd_d   = CMD_LMR;
            saddr_d = MODE_WORD;
        end
        if (go_done) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            done_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_WAIT;
            cnt       <= '0;
            ref_cnt   <= '0;
            Cke       <= 1'b0;
            Command   <= CMD_NOP;
            Saddr     <= '0;
            Ba        <= '0;
            Init_done <= 1'b0;
            Busy      <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ref_cnt   <= ref_d;
            Cke       <= 1'b1;
            Command   <= cmd_d;
            Saddr     <= saddr_d;
            Ba        <= '0;
            Init_done <= done_d;
            Busy      <= ~done_d;
        end
    end

endmodule
